// File: rtl/rv32_imm_pkg.sv
// rv32_imm_pkg: immediate format codes, opcodes and range widths shared by extender, decoder and encoder
package rv32_imm_pkg;
  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b010;
  localparam logic [2:0] FMT_J = 3'b011;
  localparam logic [2:0] FMT_U = 3'b100;
  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL = 7'h6F;
  localparam logic [6:0] OP_LUI = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam int IMM_W_IS = 12;
  localparam int IMM_W_B = 13;
  localparam int IMM_W_J = 21;
  // true when v equals the sign-extension of its low n bits
  function automatic logic fits(input logic [31:0] v, input int n);
    logic [31:0] t;
    t = 32'($signed(v) >>> (n - 1));
    return t == '0 || t == '1;
  endfunction
endpackage

// File: rtl/imm_pack.sv
// imm_pack: combinational packing of decoded fields and immediate into an RV32I word with range check
module imm_pack
  import rv32_imm_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [31:0] imm,
  output logic        err,
  output logic [31:0] instr
);
  logic ok;
  logic [31:0] raw;
  always_comb begin
    ok = 1'b0;
    raw = '0;
    case (fmt)
      FMT_I: begin
        ok = fits(imm, IMM_W_IS);
        raw = {imm[11:0], rs1, funct3, rd, opcode};
      end
      FMT_S: begin
        ok = fits(imm, IMM_W_IS);
        raw = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      end
      FMT_B: begin
        ok = fits(imm, IMM_W_B) && !imm[0];
        raw = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      end
      FMT_J: begin
        ok = fits(imm, IMM_W_J) && !imm[0];
        raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      end
      FMT_U: begin
        ok = imm[11:0] == '0;
        raw = {imm[31:12], rd, opcode};
      end
      default: ;
    endcase
    err = !ok;
    instr = ok ? raw : '0;
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: field-level instruction encoder with 2-entry output FIFO and saturating error counter
module instr_encoder
  import rv32_imm_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       fmt,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [ERR_W-1:0] err_count
);
  logic err;
  logic [31:0] instr;
  logic [32:0] head, tail;
  logic [1:0] count;
  logic push, pop;
  imm_pack u_pack (
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .imm(imm), .err(err), .instr(instr)
  );
  assign in_ready = count != 2'd2;
  assign out_valid = count != 2'd0;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign {out_err, out_instr} = head;
  // head is slot 0; a pop shifts the tail forward or takes the incoming word directly
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
      head <= '0;
      tail <= '0;
      err_count <= '0;
    end else begin
      count <= 2'(count + 2'(push) - 2'(pop));
      if (pop) head <= (count == 2'd2) ? tail : {err, instr};
      else if (push && count == 2'd0) head <= {err, instr};
      if (push && !pop && count == 2'd1) tail <= {err, instr};
      if (push && err && !(&err_count)) err_count <= err_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed table-driven checks plus handshake, streaming, reset and saturation sequences
module tb_instr_encoder;
  import rv32_imm_pkg::*;
  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [31:0] ei;
    logic        ee;
  } vec_t;
  logic clk = 0, rst = 0, in_valid = 0, in_ready, out_valid, out_ready = 0, out_err;
  logic [2:0] fmt = 0, funct3 = 0;
  logic [6:0] opcode = 0;
  logic [4:0] rd = 0, rs1 = 0, rs2 = 0;
  logic [31:0] imm = 0, out_instr;
  logic [7:0] err_count, ec_m = 0;
  int n_chk = 0, n_fail = 0;
  vec_t tbl[18];
  vec_t ev[3];
  instr_encoder #(.ERR_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .err_count(err_count)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic [2:0] f, logic [6:0] o, logic [4:0] d, logic [4:0] s1,
                              logic [4:0] s2, logic [2:0] f3, logic [31:0] im, logic [31:0] ei, logic ee);
    vec_t v;
    v.fmt = f; v.op = o; v.rd = d; v.rs1 = s1; v.rs2 = s2; v.f3 = f3; v.imm = im; v.ei = ei; v.ee = ee;
    return v;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(vec_t v);
    fmt = v.fmt; opcode = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; funct3 = v.f3; imm = v.imm;
    in_valid = 1;
  endtask
  task automatic push(vec_t v);
    int t = 0;
    @(negedge clk);
    drive(v);
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("push_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    if (v.ee && ec_m != 8'hFF) ec_m++;
    #1 in_valid = 0;
  endtask
  task automatic pop_one();
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
  endtask
  initial begin
    tbl[0]  = mk(FMT_I, OP_IMM, 1, 0, 0, 0, 32'hFFFFFFFF, 32'hFFF00093, 0);
    tbl[1]  = mk(FMT_S, OP_STORE, 0, 1, 2, 2, 32'd8, 32'h0020A423, 0);
    tbl[2]  = mk(FMT_J, OP_JAL, 1, 0, 0, 0, 32'h800, 32'h001000EF, 0);
    tbl[3]  = mk(FMT_U, OP_LUI, 5, 0, 0, 0, 32'h12345000, 32'h123452B7, 0);
    tbl[4]  = mk(FMT_B, OP_BRANCH, 0, 0, 0, 0, 32'hFFFFF000, 32'h80000063, 0);
    tbl[5]  = mk(FMT_B, OP_BRANCH, 0, 0, 0, 0, 32'h00000FFE, 32'h7E000FE3, 0);
    tbl[6]  = mk(FMT_B, OP_BRANCH, 0, 0, 0, 0, 32'h00001000, 32'h0, 1);
    tbl[7]  = mk(FMT_J, OP_JAL, 0, 0, 0, 0, 32'hFFF00000, 32'h8000006F, 0);
    tbl[8]  = mk(FMT_J, OP_JAL, 0, 0, 0, 0, 32'h00100000, 32'h0, 1);
    tbl[9]  = mk(FMT_J, OP_JAL, 0, 0, 0, 0, 32'h00000001, 32'h0, 1);
    tbl[10] = mk(FMT_I, OP_IMM, 0, 0, 0, 0, 32'hFFFFF800, 32'h80000013, 0);
    tbl[11] = mk(FMT_I, OP_IMM, 0, 0, 0, 0, 32'h000007FF, 32'h7FF00013, 0);
    tbl[12] = mk(FMT_U, OP_AUIPC, 3, 0, 0, 0, 32'h00001234, 32'h0, 1);
    tbl[13] = mk(FMT_U, OP_AUIPC, 3, 0, 0, 0, 32'hFFFFF000, 32'hFFFFF197, 0);
    tbl[14] = mk(FMT_S, OP_STORE, 0, 0, 0, 0, 32'hFFFFFFFF, 32'hFE000FA3, 0);
    tbl[15] = mk(3'b101, OP_IMM, 1, 1, 1, 1, 32'h0, 32'h0, 1);
    tbl[16] = mk(FMT_B, OP_BRANCH, 0, 0, 0, 0, 32'hFFFFE000, 32'h0, 1);
    tbl[17] = mk(FMT_I, OP_IMM, 0, 0, 0, 0, 32'hFFFFF7FF, 32'h0, 1);
    ev[0] = mk(FMT_B, OP_BRANCH, 0, 0, 0, 0, 32'd3, 32'h0, 1);
    ev[1] = mk(FMT_I, OP_IMM, 1, 1, 0, 0, 32'd2048, 32'h0, 1);
    ev[2] = mk(3'b111, OP_IMM, 1, 1, 0, 0, 32'd0, 32'h0, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_err", 32'(out_err), 0);
    chk("rst_err_count", 32'(err_count), 0);
    for (int i = 0; i < 3; i++) begin
      push(ev[i]);
      chk("errseq_valid", 32'(out_valid), 1);
      chk("errseq_err", 32'(out_err), 1);
      chk("errseq_instr", out_instr, 0);
      pop_one();
    end
    chk("errseq_count", 32'(err_count), 32'd3);
    for (int i = 0; i < 18; i++) begin
      push(tbl[i]);
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 1);
      chk($sformatf("vec%0d_instr", i), out_instr, tbl[i].ei);
      chk($sformatf("vec%0d_err", i), 32'(out_err), 32'(tbl[i].ee));
      pop_one();
      chk($sformatf("vec%0d_drain", i), 32'(out_valid), 0);
    end
    chk("tbl_err_count", 32'(err_count), 32'(ec_m));
    push(tbl[0]);
    push(tbl[1]);
    chk("bp_full", 32'(in_ready), 0);
    chk("bp_head_a", out_instr, tbl[0].ei);
    @(negedge clk);
    drive(tbl[2]);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_ready", 32'(in_ready), 0);
      chk("bp_hold_head", out_instr, tbl[0].ei);
    end
    out_ready = 1;
    @(posedge clk);
    #1;
    chk("bp_head_b", out_instr, tbl[1].ei);
    chk("bp_ready_back", 32'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 0;
    chk("bp_head_c", out_instr, tbl[2].ei);
    chk("bp_c_valid", 32'(out_valid), 1);
    @(posedge clk);
    #1;
    chk("bp_empty", 32'(out_valid), 0);
    for (int k = 0; k < 16; k++) begin
      logic [31:0] im;
      logic [4:0] r1;
      im = 32'(k * 100 - 800);
      r1 = 5'(k + 1);
      fmt = FMT_I; opcode = OP_IMM; rd = 5'(k); rs1 = r1; rs2 = 0; funct3 = 3'(k); imm = im;
      in_valid = 1;
      @(posedge clk);
      #1;
      chk($sformatf("stream%0d_valid", k), 32'(out_valid), 1);
      chk($sformatf("stream%0d_instr", k), out_instr, {im[11:0], r1, 3'(k), 5'(k), 7'h13});
      chk($sformatf("stream%0d_ready", k), 32'(in_ready), 1);
    end
    in_valid = 0;
    @(posedge clk);
    #1;
    chk("stream_drain", 32'(out_valid), 0);
    out_ready = 0;
    push(ev[2]);
    push(tbl[3]);
    chk("rm_full", 32'(in_ready), 0);
    chk("rm_count_pre", 32'(err_count), 32'(ec_m));
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1 rst = 1;
    ec_m = 0;
    chk("rm_valid", 32'(out_valid), 0);
    chk("rm_ready", 32'(in_ready), 1);
    chk("rm_err_count", 32'(err_count), 0);
    chk("rm_instr", out_instr, 0);
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rm_no_stale", 32'(out_valid), 0);
    end
    fmt = 3'b110; imm = 0;
    in_valid = 1;
    for (int k = 0; k < 260; k++) begin
      @(posedge clk);
      if (ec_m != 8'hFF) ec_m++;
      #1;
      if (k == 253) chk("sat_254", 32'(err_count), 32'd254);
      if (k == 254) chk("sat_255", 32'(err_count), 32'd255);
    end
    in_valid = 0;
    chk("sat_hold", 32'(err_count), 32'(ec_m));
    chk("sat_err_word", 32'(out_err), 1);
    @(posedge clk);
    #1 out_ready = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
